// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared opcodes, access-size codes and FSM state for the memory stage
package mem_stage_pkg;
  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;
  // undefined encodings (011, 110, 111) collapse onto word through func3[1]
  function automatic size_e size_of(input logic [2:0] f3);
    return f3[1] ? SZ_W : f3[0] ? SZ_H : SZ_B;
  endfunction
endpackage

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: store strobe/data lanes, misalignment check and load lane extraction
module lsu_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr,
  input  logic [31:0] wsrc,
  input  logic [31:0] rdata,
  output logic        misalign,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);
  size_e       sz;
  logic        sx;
  logic [7:0]  lb;
  logic [15:0] lh;
  always_comb begin
    sz = size_of(func3);
    sx = !func3[2];
    lb = rdata[{addr, 3'b000} +: 8];
    lh = rdata[{addr[1], 4'b0000} +: 16];
    misalign = (sz == SZ_H && addr[0]) || (sz == SZ_W && addr != 2'b00);
    wstrb = sz == SZ_W ? 4'b1111 : sz == SZ_H ? 4'b0011 << addr : 4'b0001 << addr;
    wdata = sz == SZ_W ? wsrc : sz == SZ_H ? {2{wsrc[15:0]}} : {4{wsrc[7:0]}};
    ldata = sz == SZ_W ? rdata : sz == SZ_H ? {{16{sx & lh[15]}}, lh} : {{24{sx & lb[7]}}, lb};
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with a req/gnt/rvalid data-memory handshake and response timeout
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [4:0]      ex_opcode,
  input  logic [2:0]      ex_func3,
  input  logic [XLEN-1:0] ex_alu_out,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [4:0]      ex_rd,
  output logic            stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_wstrb,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            exc_misalign,
  output logic            exc_bus
);
  state_e          state, state_nx;
  logic            idle, is_store, is_mem, accept, timeout;
  logic [7:0]      cnt;
  logic            we_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic [3:0]      strb_q;
  logic            a_mis;
  logic [3:0]      a_strb;
  logic [XLEN-1:0] a_wdata, a_ldata;

  assign idle     = state == ST_IDLE;
  assign is_store = ex_opcode == OP_STORE;
  assign is_mem   = ex_opcode == OP_LOAD || is_store;
  assign accept   = idle && ex_valid && is_mem && !a_mis;
  assign timeout  = state == ST_WAIT && !dmem_rvalid && cnt >= 8'(RESP_TIMEOUT - 1);

  // one aligner serves both the incoming op (IDLE) and the latched op (REQ/WAIT)
  lsu_align u_align (
    .func3    (idle ? ex_func3 : f3_q),
    .addr     (idle ? ex_alu_out[1:0] : addr_q[1:0]),
    .wsrc     (ex_rs2),
    .rdata    (dmem_rdata),
    .misalign (a_mis),
    .wstrb    (a_strb),
    .wdata    (a_wdata),
    .ldata    (a_ldata)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = idle ? (accept ? ST_REQ : ST_IDLE)
             : state == ST_REQ ? (dmem_gnt ? ST_WAIT : ST_REQ)
             : (dmem_rvalid || timeout) ? ST_IDLE : ST_WAIT;
    stall = accept || state == ST_REQ || (state == ST_WAIT && !dmem_rvalid);
  end

  assign dmem_req   = state == ST_REQ;
  assign dmem_we    = dmem_req && we_q;
  assign dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign dmem_wstrb = strb_q;
  assign dmem_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
      f3_q         <= '0;
      rd_q         <= '0;
      cnt          <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      exc_misalign <= 1'b0;
      exc_bus      <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      exc_misalign <= 1'b0;
      exc_bus      <= 1'b0;
      if (idle && ex_valid) begin
        if (!is_mem) begin
          wb_valid <= 1'b1;
          wb_rd    <= ex_rd;
          wb_data  <= ex_alu_out;
        end else if (a_mis) exc_misalign <= 1'b1;
        else begin
          we_q    <= is_store;
          addr_q  <= ex_alu_out;
          f3_q    <= ex_func3;
          rd_q    <= ex_rd;
          strb_q  <= is_store ? a_strb : 4'b0000;
          wdata_q <= is_store ? a_wdata : '0;
        end
      end
      if (state == ST_WAIT) begin
        cnt <= cnt == 8'hFF ? cnt : cnt + 8'd1;
        if (dmem_rvalid && !we_q) begin
          wb_valid <= 1'b1;
          wb_rd    <= rd_q;
          wb_data  <= a_ldata;
        end
        if (timeout) exc_bus <= 1'b1;
      end else cnt <= '0;
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus with a scoreboard queue checked by an output monitor
module tb_mem_stage;
  import mem_stage_pkg::*;
  logic        clk = 0, rst_n = 0;
  logic        ex_valid = 0;
  logic [4:0]  ex_opcode = 0, ex_rd = 0;
  logic [2:0]  ex_func3 = 0;
  logic [31:0] ex_alu_out = 0, ex_rs2 = 0;
  logic        stall, dmem_req, dmem_we, dmem_gnt = 0, dmem_rvalid = 0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 0;
  logic [3:0]  dmem_wstrb;
  logic        wb_valid, exc_misalign, exc_bus;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  int nchk = 0, nerr = 0, nreq = 0;
  localparam logic [4:0] OP_ALU = 5'b01100;

  typedef struct {int kind; logic [31:0] a; logic [31:0] d; logic [3:0] s; logic we;} ev_t;
  ev_t sbq[$];

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_func3(ex_func3),
    .ex_alu_out(ex_alu_out), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_misalign(exc_misalign), .exc_bus(exc_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic we);
    ev_t e;
    e.kind = k; e.a = a; e.d = d; e.s = s; e.we = we;
    sbq.push_back(e);
  endtask

  // kinds: 0 write-back, 1 granted memory request, 2 misalign exception, 3 bus exception
  task automatic observe(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic we);
    ev_t e;
    if (sbq.size() == 0) begin
      nchk++; nerr++;
      $display("FAIL unexpected_event: got kind=%0d a=%h d=%h expected none", k, a, d);
      return;
    end
    e = sbq.pop_front();
    check("ev_kind", k, e.kind);
    if (k == e.kind && k == 0) begin
      check("wb_rd", a, e.a);
      check("wb_data", d, e.d);
    end
    if (k == e.kind && k == 1) begin
      check("mem_addr", a, e.a);
      check("mem_we", {31'b0, we}, {31'b0, e.we});
      if (e.we) begin
        check("mem_wstrb", {28'b0, s}, {28'b0, e.s});
        check("mem_wdata", d, e.d);
      end
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (dmem_req) nreq++;
    if (wb_valid) observe(0, {27'b0, wb_rd}, wb_data, 4'b0, 1'b0);
    if (dmem_req && dmem_gnt) observe(1, dmem_addr, dmem_wdata, dmem_wstrb, dmem_we);
    if (exc_misalign) observe(2, 0, 0, 4'b0, 1'b0);
    if (exc_bus) observe(3, 0, 0, 4'b0, 1'b0);
  end

  task automatic check_reset_outs();
    check("rst_stall", {31'b0, stall}, 0);
    check("rst_req", {31'b0, dmem_req}, 0);
    check("rst_we", {31'b0, dmem_we}, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_wstrb", {28'b0, dmem_wstrb}, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_wb_valid", {31'b0, wb_valid}, 0);
    check("rst_wb_rd", {27'b0, wb_rd}, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_exc", {30'b0, exc_misalign, exc_bus}, 0);
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] val);
    ex_valid = 1; ex_opcode = OP_ALU; ex_rd = rd; ex_alu_out = val; ex_func3 = 0;
    push(0, {27'b0, rd}, val, 4'b0, 1'b0);
    @(negedge clk) check("alu_stall0", {31'b0, stall}, 0);
    @(posedge clk) #1 ex_valid = 0;
    @(negedge clk) check("alu_stall1", {31'b0, stall}, 0);
    @(posedge clk) #1;
  endtask

  task automatic mem_op(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [4:0] rd, input int gdly, input int rdly,
                        input logic [31:0] rdata, input logic [3:0] estrb, input logic [31:0] ewdata,
                        input logic [31:0] eload);
    ex_valid = 1; ex_opcode = op; ex_func3 = f3; ex_alu_out = addr; ex_rs2 = rs2; ex_rd = rd;
    push(1, {addr[31:2], 2'b00}, ewdata, estrb, op == OP_STORE);
    if (op == OP_LOAD) push(0, {27'b0, rd}, eload, 4'b0, 1'b0);
    @(negedge clk) check("acc_stall", {31'b0, stall}, 1);
    @(posedge clk) #1 ex_valid = 0;
    for (int i = 0; i <= gdly; i++) begin
      dmem_gnt = i == gdly;
      @(negedge clk);
      check("req_hold", {31'b0, dmem_req}, 1);
      check("addr_hold", dmem_addr, {addr[31:2], 2'b00});
      @(posedge clk) #1;
    end
    dmem_gnt = 0;
    repeat (rdly) @(posedge clk);
    #1 dmem_rvalid = 1; dmem_rdata = rdata;
    @(negedge clk) check("rvalid_stall", {31'b0, stall}, 0);
    @(posedge clk) #1 dmem_rvalid = 0;
  endtask

  task automatic mis_op(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] addr);
    int r0;
    r0 = nreq;
    ex_valid = 1; ex_opcode = op; ex_func3 = f3; ex_alu_out = addr; ex_rd = 5'd9;
    push(2, 0, 0, 4'b0, 1'b0);
    @(negedge clk) check("mis_stall", {31'b0, stall}, 0);
    @(posedge clk) #1 ex_valid = 0;
    repeat (2) @(posedge clk);
    #1 check("mis_noreq", nreq, r0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check_reset_outs();
    rst_n = 1;
    alu_op(5'd5, 32'h0000_1234);
    alu_op(5'd0, 32'hFFFF_0001);
    mem_op(OP_STORE, F3_B, 32'h103, 32'hAB, 5'd0, 2, 1, 0, 4'b1000, 32'hABAB_ABAB, 0);
    mem_op(OP_LOAD, F3_B, 32'h101, 0, 5'd3, 0, 1, 32'h0000_8000, 0, 0, 32'hFFFF_FF80);
    mem_op(OP_LOAD, F3_BU, 32'h101, 0, 5'd4, 0, 1, 32'h0000_8000, 0, 0, 32'h0000_0080);
    mem_op(OP_LOAD, F3_H, 32'h202, 0, 5'd6, 1, 0, 32'h8001_0000, 0, 0, 32'hFFFF_8001);
    mem_op(OP_LOAD, F3_HU, 32'h202, 0, 5'd6, 0, 2, 32'h8001_0000, 0, 0, 32'h0000_8001);
    mem_op(OP_STORE, F3_H, 32'h206, 32'h1234_BEEF, 5'd0, 0, 0, 0, 4'b1100, 32'hBEEF_BEEF, 0);
    mem_op(OP_STORE, 3'b011, 32'h14, 32'h1234_5678, 5'd0, 1, 0, 0, 4'b1111, 32'h1234_5678, 0);
    mem_op(OP_LOAD, 3'b111, 32'h10, 0, 5'd8, 0, 0, 32'hCAFE_F00D, 0, 0, 32'hCAFE_F00D);
    mis_op(OP_LOAD, F3_H, 32'h201);
    mis_op(OP_STORE, F3_W, 32'h102);
    mis_op(OP_LOAD, 3'b110, 32'h2);
    #1 dmem_rvalid = 1; dmem_rdata = 32'h5555_5555;
    @(posedge clk) #1 dmem_rvalid = 0;
    // response timeout
    ex_valid = 1; ex_opcode = OP_LOAD; ex_func3 = F3_W; ex_alu_out = 32'h300; ex_rd = 5'd10;
    push(1, 32'h300, 0, 4'b0, 1'b0);
    push(3, 0, 0, 4'b0, 1'b0);
    dmem_gnt = 1;
    @(posedge clk) #1 ex_valid = 0;
    @(posedge clk) #1 dmem_gnt = 0;
    begin
      int k;
      k = 0;
      for (int i = 1; i <= 400; i++) begin
        @(negedge clk);
        if (exc_bus) begin k = i; break; end
      end
      check("timeout_cycles", k, 256);
      check("timeout_stall", {31'b0, stall}, 0);
    end
    @(posedge clk) #1;
    // reset during WAIT abandons the load
    ex_valid = 1; ex_opcode = OP_LOAD; ex_func3 = F3_W; ex_alu_out = 32'h400; ex_rd = 5'd7;
    push(1, 32'h400, 0, 4'b0, 1'b0);
    @(posedge clk) #1 ex_valid = 0; dmem_gnt = 1;
    @(posedge clk) #1 dmem_gnt = 0;
    @(posedge clk) #1 rst_n = 0; dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk) check_reset_outs();
    @(posedge clk) #1 rst_n = 1;
    @(posedge clk) #1 dmem_rvalid = 0;
    @(negedge clk) check("post_rst_wb", {31'b0, wb_valid}, 0);
    @(posedge clk) #1;
    alu_op(5'd31, 32'h8765_4321);
    repeat (3) @(posedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
